// File: rtl/uartm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uartm_pkg
// Description : Register map, STAT/CTRL bit positions and FSM encoding shared
//               by the uartm peripheral and its receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uartm_pkg;

    localparam logic [1:0] C_ADDR_DR   = 2'd0;
    localparam logic [1:0] C_ADDR_BRR  = 2'd1;
    localparam logic [1:0] C_ADDR_STAT = 2'd2;
    localparam logic [1:0] C_ADDR_CTRL = 2'd3;

    localparam int C_STAT_RX_FULL  = 0;
    localparam int C_STAT_TX_EMPTY = 1;
    localparam int C_STAT_TX_BUSY  = 2;
    localparam int C_STAT_OVR      = 3;
    localparam int C_STAT_FERR     = 4;

    localparam int C_CTRL_TX_EN = 0;
    localparam int C_CTRL_RX_EN = 1;
    localparam int C_CTRL_RXIE  = 2;
    localparam int C_CTRL_TXIE  = 3;

    localparam logic [15:0] C_BRR_MIN = 16'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Very short bit periods would leave no room for the mid-bit sample point.
    function automatic logic [15:0] eff_brr(input logic [15:0] brr);
        return (brr < C_BRR_MIN) ? C_BRR_MIN : brr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uartm_rx.sv
`default_nettype none
// ============================================================================
// Module      : uartm_rx
// Description : 8N1 receiver: input synchroniser, RX FSM and bit timer;
//               emits the byte with one-cycle done / framing-error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uartm_rx
    import uartm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_en,
    input  logic [15:0] bit_period,
    input  logic        rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_done,
    output logic        rx_ferr
);

    logic        sync1_q, sync2_q, sync_prev_q;
    uart_state_e state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        fall;
    logic [15:0] start_wait;

    assign fall       = sync_prev_q & ~sync2_q;
    assign start_wait = {1'b0, bit_period[15:1]} + {15'd0, bit_period[0]} - 16'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_en && fall) begin
                    state_d = ST_START;
                    timer_d = start_wait;
                end
            end
            ST_START: begin
                if (timer_q == 16'd0) begin
                    if (sync2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        timer_d = bit_period;
                        bit_d   = 3'd0;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_q == 16'd0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    timer_d = bit_period;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                if (timer_q == 16'd0) begin
                    state_d = ST_IDLE;
                    done_d  = sync2_q;
                    ferr_d  = ~sync2_q;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= 16'd0;
            shift_q     <= 8'd0;
            bit_q       <= 3'd0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
        end
    end

    assign rx_byte = shift_q;
    assign rx_done = done_q;
    assign rx_ferr = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uartm.sv
`default_nettype none
// ============================================================================
// Module      : uartm
// Description : Memory-mapped 8N1 UART: TX holding register and TX FSM,
//               register file, combinational read mux, RX via uartm_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module uartm
    import uartm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BRR_RESET = 217
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             rxd,
    output logic             txd,
    output logic             irq
);

    logic [15:0] brr_q, brr_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  hold_q, hold_d;
    logic        tx_empty_q, tx_empty_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        irq_q, irq_d;
    uart_state_e tx_state_q, tx_state_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_timer_q, tx_timer_d;
    logic        txd_q, txd_d;

    logic        wr_dr, wr_brr, wr_stat, wr_ctrl;
    logic        tx_load, dr_accept, tx_busy;
    logic        clr_full, clr_ovr, clr_ferr;
    logic [15:0] period;
    logic [7:0]  rx_byte;
    logic        rx_done, rx_ferr;
    logic        unused_din;

    assign unused_din = ^din[WIDTH-1:16];
    assign period     = eff_brr(brr_q);
    assign wr_dr      = cs && wen && (addr == C_ADDR_DR);
    assign wr_brr     = cs && wen && (addr == C_ADDR_BRR);
    assign wr_stat    = cs && wen && (addr == C_ADDR_STAT);
    assign wr_ctrl    = cs && wen && (addr == C_ADDR_CTRL);
    assign clr_full   = wr_stat && din[C_STAT_RX_FULL];
    assign clr_ovr    = wr_stat && din[C_STAT_OVR];
    assign clr_ferr   = wr_stat && din[C_STAT_FERR];
    assign tx_busy    = (tx_state_q != ST_IDLE);

    // Holding register is consumed from IDLE or at the last cycle of STOP,
    // the latter chaining frames back to back.
    assign tx_load   = ctrl_q[C_CTRL_TX_EN] && !tx_empty_q &&
                       ((tx_state_q == ST_IDLE) ||
                        ((tx_state_q == ST_STOP) && (tx_timer_q == 16'd0)));
    assign dr_accept = wr_dr && (tx_empty_q || tx_load);

    uartm_rx u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_en      (ctrl_q[C_CTRL_RX_EN]),
        .bit_period (period),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .rx_ferr    (rx_ferr)
    );

    always_comb begin
        brr_d      = wr_brr  ? din[15:0] : brr_q;
        ctrl_d     = wr_ctrl ? din[3:0]  : ctrl_q;
        hold_d     = hold_q;
        tx_empty_d = tx_empty_q;
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_timer_d = tx_timer_q;
        txd_d      = txd_q;

        case (tx_state_q)
            ST_IDLE: begin
                if (tx_load) begin
                    tx_state_d = ST_START;
                    tx_shift_d = hold_q;
                    tx_timer_d = period;
                    txd_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_timer_q == 16'd0) begin
                    tx_state_d = ST_DATA;
                    tx_timer_d = period;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_timer_q == 16'd0) begin
                    tx_timer_d = period;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
            default: begin
                if (tx_timer_q == 16'd0) begin
                    if (tx_load) begin
                        tx_state_d = ST_START;
                        tx_shift_d = hold_q;
                        tx_timer_d = period;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_timer_d = tx_timer_q - 16'd1;
                end
            end
        endcase

        if (tx_load) begin
            tx_empty_d = 1'b1;
        end
        if (dr_accept) begin
            hold_d     = din[7:0];
            tx_empty_d = 1'b0;
        end

        // A completing byte wins over a same-cycle clear of rx_full.
        rx_full_d = clr_full ? 1'b0 : rx_full_q;
        rx_data_d = rx_data_q;
        ovr_d     = clr_ovr  ? 1'b0 : ovr_q;
        ferr_d    = (clr_ferr ? 1'b0 : ferr_q) | rx_ferr;
        if (rx_done) begin
            if (!rx_full_q || clr_full) begin
                rx_full_d = 1'b1;
                rx_data_d = rx_byte;
            end else begin
                ovr_d = 1'b1;
            end
        end

        irq_d = (rx_full_q && ctrl_q[C_CTRL_RXIE]) || (tx_empty_q && ctrl_q[C_CTRL_TXIE]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brr_q      <= 16'(BRR_RESET);
            ctrl_q     <= 4'd0;
            hold_q     <= 8'd0;
            tx_empty_q <= 1'b1;
            rx_full_q  <= 1'b0;
            rx_data_q  <= 8'd0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_shift_q <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_timer_q <= 16'd0;
            txd_q      <= 1'b1;
        end else begin
            brr_q      <= brr_d;
            ctrl_q     <= ctrl_d;
            hold_q     <= hold_d;
            tx_empty_q <= tx_empty_d;
            rx_full_q  <= rx_full_d;
            rx_data_q  <= rx_data_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_timer_q <= tx_timer_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                C_ADDR_DR:   dout = WIDTH'(rx_data_q);
                C_ADDR_BRR:  dout = WIDTH'(brr_q);
                C_ADDR_STAT: dout = WIDTH'({ferr_q, ovr_q, tx_busy, tx_empty_q, rx_full_q});
                default:     dout = WIDTH'(ctrl_q);
            endcase
        end
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uartm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uartm
// Description : Directed self-checking bench for the uartm peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uartm;

    localparam int WIDTH = 32;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             cs    = 1'b0;
    logic             wen   = 1'b0;
    logic [1:0]       addr  = 2'd0;
    logic [WIDTH-1:0] din   = '0;
    logic [WIDTH-1:0] dout;
    logic             rxd   = 1'b1;
    logic             txd;
    logic             irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt;
    logic        seen;
    logic        found;
    logic        stay_high;
    logic [31:0] r;

    uartm #(.WIDTH(WIDTH), .BRR_RESET(217)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .wen   (wen),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .rxd   (rxd),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; addr = a;
        #1;
        d  = dout;
        cs = 1'b0;
    endtask

    // Entered at mid start bit; samples ten bits four clocks apart.
    task automatic check_tx_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(bits[k]));
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            repeat (4) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        bus_read(2'd1, r); check("rst_brr",  r, 32'd217);
        bus_read(2'd2, r); check("rst_stat", r, 32'h02);
        bus_read(2'd3, r); check("rst_ctrl", r, 32'h00);
        bus_read(2'd0, r); check("rst_dr",   r, 32'h00);
        check("cs_low_dout", dout, 32'h0);

        // Single TX frame 0xA5
        @(negedge clk);
        bus_write(2'd1, 32'd3);
        bus_read(2'd1, r); check("brr_rd", r, 32'd3);
        @(negedge clk);
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'hA5);
        repeat (3) @(negedge clk);
        check_tx_frame("tx_a5", 8'hA5);

        // tx_busy duration
        repeat (10) @(negedge clk);
        bus_write(2'd0, 32'hA5);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_read(2'd2, r);
            if (r[2]) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        check("tx_busy_len", 32'(cnt), 32'd40);

        // Back-to-back frames, third write while holding full is dropped
        repeat (10) @(negedge clk);
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        bus_write(2'd0, 32'h33);
        @(negedge clk);
        check_tx_frame("tx_11", 8'h11);
        check_tx_frame("tx_22", 8'h22);
        stay_high = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!txd) stay_high = 1'b0;
            @(negedge clk);
        end
        check("tx_third_dropped", 32'(stay_high), 32'd1);
        bus_read(2'd2, r); check("tx_idle_stat", r, 32'h02);

        // TX-empty interrupt
        @(negedge clk);
        bus_write(2'd3, 32'h8);
        repeat (2) @(negedge clk);
        check("irq_txie", 32'(irq), 32'd1);

        // RX byte 0x3C
        bus_write(2'd3, 32'h2);
        repeat (2) @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);
        send_rx(8'h3C, 1'b1);
        bus_read(2'd2, r); check("rx_full_set", r, 32'h03);
        bus_read(2'd0, r); check("rx_dr_3c", r, 32'h3C);
        @(negedge clk);
        bus_write(2'd3, 32'h6);
        repeat (2) @(negedge clk);
        check("irq_rxie", 32'(irq), 32'd1);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, r); check("rx_full_clr", r, 32'h02);
        @(negedge clk);
        bus_write(2'd3, 32'h2);

        // Overrun: 0x3C loads, 0x55 overruns and is dropped
        send_rx(8'h3C, 1'b1);
        send_rx(8'h55, 1'b1);
        bus_read(2'd2, r); check("rx_ovr_stat", r, 32'h0B);
        bus_read(2'd0, r); check("rx_ovr_dr", r, 32'h3C);
        @(negedge clk);
        bus_write(2'd2, 32'h09);
        bus_read(2'd2, r); check("rx_ovr_clr", r, 32'h02);

        // Framing error: bad stop bit, byte discarded
        @(negedge clk);
        send_rx(8'h66, 1'b0);
        bus_read(2'd2, r); check("rx_ferr_stat", r, 32'h12);
        bus_read(2'd0, r); check("rx_ferr_dr", r, 32'h3C);
        @(negedge clk);
        bus_write(2'd2, 32'h10);
        bus_read(2'd2, r); check("rx_ferr_clr", r, 32'h02);

        // One-clock glitch is a false start; receiver still works afterwards
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(2'd2, r); check("rx_glitch_stat", r, 32'h02);
        @(negedge clk);
        send_rx(8'hA7, 1'b1);
        bus_read(2'd0, r); check("rx_after_glitch_dr", r, 32'hA7);
        bus_read(2'd2, r); check("rx_after_glitch_stat", r, 32'h03);

        // rx_full clear on every cycle; the completion cycle must still load
        @(negedge clk);
        found = 1'b0;
        fork
            send_rx(8'h81, 1'b1);
            begin
                for (int i = 0; i < 100 && !found; i++) begin
                    cs = 1'b1; wen = 1'b1; addr = 2'd2; din = 32'h1;
                    @(negedge clk);
                    wen = 1'b0; din = '0;
                    #1;
                    if (dout[0]) found = 1'b1;
                end
                cs = 1'b0;
            end
        join
        check("coinc_full", 32'(found), 32'd1);
        @(negedge clk);
        bus_read(2'd0, r); check("coinc_dr", r, 32'h81);
        bus_read(2'd2, r); check("coinc_no_ovr", 32'(r[3]), 32'd0);

        // Reset in the middle of a TX frame
        @(negedge clk);
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h00);
        repeat (10) @(negedge clk);
        check("mid_frame_txd", 32'(txd), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_txd", 32'(txd), 32'd1);
        bus_read(2'd2, r); check("rst_mid_stat", r, 32'h02);
        bus_read(2'd1, r); check("rst_mid_brr", r, 32'd217);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
